mio_bus_ctrl: RTL and testbench
===============================

Name: mio_bus_ctrl

Overview:
- Memory/IO bus controller directly downstream of the multi-cycle CPU.
- Consumes the CPU bus request: CPU_MIO, mem_w, Addr_out, Data_out.
- Returns Data_in and the MIO_ready handshake to the CPU.
- Decodes each access to an external synchronous block RAM, a 7-segment data register, LED/switch port, or a down-counter; the counter raises the CPU INT line.

Parameters:
RAM_AW, 10, RAM word-address width (RAM size = 2^RAM_AW words)
LED_W, 8, LED output width
SW_W, 16, switch input width (SW_W <= 32)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
CPU_MIO  in  1  CPU bus request; held with addr/data/mem_w until MIO_ready seen
mem_w  in  1  1 = write, 0 = read
Addr_out  in  32  byte address from CPU
Data_out  in  32  write data from CPU
Data_in  out  32  read data to CPU
MIO_ready  out  1  one-cycle transaction-complete pulse
ram_addr  out  RAM_AW  RAM word address
ram_din  out  32  RAM write data
ram_we  out  1  RAM write enable
ram_dout  in  32  RAM read data, valid 1 cycle after ram_addr
sw  in  SW_W  switch inputs
led  out  LED_W  LED register
seg  out  32  7-segment data register
counter_int  out  1  counter interrupt to CPU INT
addr_err  out  1  one-cycle pulse on access to an unmapped address

Behaviour:
- Reset (synchronous, highest priority):
  - State -> IDLE.
  - MIO_ready=0, Data_in=0, ram_we=0, led=0, seg=0, counter=0, counter_int=0, addr_err=0.
  - Any in-flight transaction is dropped: no MIO_ready, no register write.
  - ram_we is gated by ~reset.
- Address decode (registered in IDLE on request accept):
  - RAM: Addr_out[31:RAM_AW+2]==0; ram_addr=Addr_out[RAM_AW+1:2].
  - SEG: Addr_out[31:2]==0xE000_0000>>2; R/W.
  - PORT: Addr_out[31:2]==0xF000_0000>>2; read {zero-extend sw}, write led<=Data_out[LED_W-1:0].
  - CNT: Addr_out[31:2]==0xF000_0004>>2; R/W.
  - Otherwise unmapped: read returns 0, write ignored, addr_err pulses in the ACCESS cycle, MIO_ready still issued.
  - Addr_out[1:0] ignored everywhere.
- FSM states: IDLE, ACCESS, DONE.
  - IDLE: if CPU_MIO=1 (cycle T), latch addr/wdata/mem_w/decode, go to ACCESS.
  - ACCESS (T+1):
    - RAM write: ram_we=1, ram_din=wdata.
    - RAM read: ram_addr held.
    - IO write: update target register at end of cycle.
    - IO read: capture value.
  - DONE (T+2):
    - MIO_ready=1 for exactly this cycle.
    - Data_in updated at start of DONE: RAM read -> ram_dout captured at end of ACCESS; IO read -> captured value.
    - Go to IDLE.
- Fixed latency: MIO_ready asserts 2 cycles after the request is sampled, for every target.
- Data_in holds its value until the next read completes; writes do not change Data_in.
- CPU_MIO still high in IDLE after DONE is treated as a new transaction. CPU must deassert in the cycle after MIO_ready.
- ram_we is asserted only in ACCESS with mem_w=1 and a RAM target; 0 otherwise.
- Counter (32-bit):
  - Each cycle: if counter!=0, counter<=counter-1.
  - On transition 1->0, counter_int<=1 (sticky).
  - CPU write to CNT: counter<=Data_out, counter_int<=0. Write has priority over decrement and interrupt set in the same cycle.
  - Write of 0 leaves the counter stopped and the interrupt clear.
  - CNT read returns the counter value at the ACCESS cycle.

Test Plan:
1. Reset, then write 0x0000_0010 data 0xDEADBEEF, read back -> ram_we high exactly in T+1 with ram_addr=4; MIO_ready at T+2 each time; Data_in=0xDEADBEEF.
2. Write 0xE000_0000 data 0x1234_5678; write 0xF000_0000 data 0x1A5; sw=0xBEEF, read 0xF000_0000 -> seg=0x12345678, led=0xA5, Data_in=0x0000BEEF.
3. Write CNT=3 -> counter 2,1,0 on following cycles; counter_int rises the cycle count hits 0 and stays high; write CNT=5 -> counter_int clears; CNT write landing on the 1->0 cycle -> counter_int stays 0, counter=new value.
4. Read 0x8000_0000 -> addr_err pulse at T+1, MIO_ready at T+2, Data_in=0; write to the same address -> no register or RAM change.
5. Assert reset during ACCESS of a RAM write -> ram_we=0, no MIO_ready, state IDLE, outputs at reset values.
6. Hold CPU_MIO high across two reads of different RAM words -> two MIO_ready pulses 3 cycles apart, each with the correct Data_in.

Source files
------------

// File: rtl/mio_bus_ctrl.sv
// Memory/IO bus controller between the multi-cycle CPU and block RAM, 7-seg, LED/switch port and a down-counter.
// Every access takes a fixed IDLE -> ACCESS -> DONE path, so MIO_ready always lands two cycles after the request.
//   state    | meaning
//   S_IDLE   | wait for CPU_MIO, latch request and decode
//   S_ACCESS | perform RAM/IO access, capture read data
//   S_DONE   | MIO_ready pulse, Data_in valid
module mio_bus_ctrl #(
  parameter int RAM_AW = 10,
  parameter int LED_W  = 8,
  parameter int SW_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              CPU_MIO,
  input  logic              mem_w,
  input  logic [31:0]       Addr_out,
  input  logic [31:0]       Data_out,
  output logic [31:0]       Data_in,
  output logic              MIO_ready,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_din,
  output logic              ram_we,
  input  logic [31:0]       ram_dout,
  input  logic [SW_W-1:0]   sw,
  output logic [LED_W-1:0]  led,
  output logic [31:0]       seg,
  output logic              counter_int,
  output logic              addr_err
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;
  typedef enum logic [2:0] {T_RAM, T_SEG, T_PORT, T_CNT, T_NONE} tgt_t;

  localparam logic [29:0] SEG_WA  = 30'(32'hE000_0000 >> 2);
  localparam logic [29:0] PORT_WA = 30'(32'hF000_0000 >> 2);
  localparam logic [29:0] CNT_WA  = 30'(32'hF000_0004 >> 2);

  state_t              r_state;
  tgt_t                r_tgt;
  logic                r_we;
  logic [RAM_AW-1:0]   r_waddr;
  logic [31:0]         r_wdata;
  logic [31:0]         r_data_in;
  logic                r_ready;
  logic                r_addr_err;
  logic [LED_W-1:0]    r_led;
  logic [31:0]         r_seg;
  logic [31:0]         r_counter;
  logic                r_int;

  tgt_t                w_tgt;
  logic [31:0]         w_sw32;
  logic                w_cnt_wr;
  logic                w_unused;

  always_comb begin
    w_tgt = T_NONE;
    if (Addr_out[31:RAM_AW+2] == '0)   w_tgt = T_RAM;
    else if (Addr_out[31:2] == SEG_WA)  w_tgt = T_SEG;
    else if (Addr_out[31:2] == PORT_WA) w_tgt = T_PORT;
    else if (Addr_out[31:2] == CNT_WA)  w_tgt = T_CNT;
  end

  assign w_sw32   = 32'(sw);
  assign w_cnt_wr = (r_state == S_ACCESS) && r_we && (r_tgt == T_CNT);
  assign w_unused = ^Addr_out[1:0];

  // In IDLE the RAM sees the live CPU address so ram_dout is already valid during ACCESS.
  assign ram_addr    = (r_state == S_IDLE) ? Addr_out[RAM_AW+1:2] : r_waddr;
  assign ram_din     = r_wdata;
  assign ram_we      = (r_state == S_ACCESS) && r_we && (r_tgt == T_RAM) && !reset;
  assign Data_in     = r_data_in;
  assign MIO_ready   = r_ready;
  assign addr_err    = r_addr_err;
  assign led         = r_led;
  assign seg         = r_seg;
  assign counter_int = r_int;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_tgt      <= T_NONE;
      r_we       <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
      r_data_in  <= '0;
      r_ready    <= 1'b0;
      r_addr_err <= 1'b0;
      r_led      <= '0;
      r_seg      <= '0;
    end else begin
      r_ready    <= 1'b0;
      r_addr_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (CPU_MIO) begin
            r_tgt      <= w_tgt;
            r_we       <= mem_w;
            r_waddr    <= Addr_out[RAM_AW+1:2];
            r_wdata    <= Data_out;
            r_addr_err <= (w_tgt == T_NONE);
            r_state    <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (r_we) begin
            case (r_tgt)
              T_SEG:   r_seg <= r_wdata;
              T_PORT:  r_led <= r_wdata[LED_W-1:0];
              default: ;
            endcase
          end else begin
            case (r_tgt)
              T_RAM:   r_data_in <= ram_dout;
              T_SEG:   r_data_in <= r_seg;
              T_PORT:  r_data_in <= w_sw32;
              T_CNT:   r_data_in <= r_counter;
              default: r_data_in <= '0;
            endcase
          end
          r_ready <= 1'b1;
          r_state <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // CPU load wins over both the decrement and the sticky interrupt set.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_counter <= '0;
      r_int     <= 1'b0;
    end else if (w_cnt_wr) begin
      r_counter <= r_wdata;
      r_int     <= 1'b0;
    end else if (r_counter != 32'd0) begin
      r_counter <= r_counter - 32'd1;
      if (r_counter == 32'd1) r_int <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mio_bus_ctrl.sv
// Bench for mio_bus_ctrl: directed scenarios plus randomized bus traffic against a transaction-level model.
module tb_mio_bus_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        CPU_MIO, mem_w;
  logic [31:0] Addr_out, Data_out, Data_in;
  logic        MIO_ready;
  logic [9:0]  ram_addr;
  logic [31:0] ram_din, ram_dout;
  logic        ram_we;
  logic [15:0] sw;
  logic [7:0]  led;
  logic [31:0] seg;
  logic        counter_int, addr_err;

  mio_bus_ctrl #(.RAM_AW(10), .LED_W(8), .SW_W(16)) dut (
    .clk(clk), .reset(reset), .CPU_MIO(CPU_MIO), .mem_w(mem_w),
    .Addr_out(Addr_out), .Data_out(Data_out), .Data_in(Data_in),
    .MIO_ready(MIO_ready), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_we(ram_we), .ram_dout(ram_dout), .sw(sw), .led(led), .seg(seg),
    .counter_int(counter_int), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // external synchronous block RAM
  logic [31:0] mem [0:1023];
  initial for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // reference model: storage contents plus counter described by its last load
  logic [31:0] m_ram [int];
  logic [31:0] m_seg, m_din, m_load;
  logic [7:0]  m_led;
  longint      m_lc;
  bit          chained = 1'b0;
  longint      last_rdy = 0;

  function automatic int tgt_of(input logic [31:0] a);
    if ((a >> 12) == 0)                 return 0;
    if ((a >> 2) == (32'hE000_0000 >> 2)) return 1;
    if ((a >> 2) == (32'hF000_0000 >> 2)) return 2;
    if ((a >> 2) == (32'hF000_0004 >> 2)) return 3;
    return 4;
  endfunction

  function automatic logic [31:0] cnt_at(input longint c);
    longint d = c - m_lc;
    if (d >= longint'(m_load)) return 32'h0;
    return m_load - 32'(d);
  endfunction

  function automatic logic int_at(input longint c);
    return (m_load != 0) && ((c - m_lc) >= longint'(m_load));
  endfunction

  function automatic logic [31:0] ram_rd(input int w);
    if (m_ram.exists(w)) return m_ram[w];
    return 32'h0;
  endfunction

  task automatic tick_chk(input int n);
    repeat (n) begin
      @(negedge clk);
      chk("int_idle", 32'(counter_int), 32'(int_at(cyc)));
      chk("rdy_idle", 32'(MIO_ready), 32'h0);
    end
  endtask

  // Caller is at a negedge of an IDLE cycle, or right after a hold=1 call (DONE cycle).
  task automatic tx(input bit we, input logic [31:0] a, input logic [31:0] d, input bit hold);
    int t;
    int w;
    logic [31:0] exp;
    t = tgt_of(a);
    w = int'(a[11:2]);
    CPU_MIO = 1'b1; mem_w = we; Addr_out = a; Data_out = d;
    if (chained) begin
      @(negedge clk);
      chk("rdy_gap_idle", 32'(MIO_ready), 32'h0);
    end
    @(negedge clk);
    chk("rdy_access", 32'(MIO_ready), 32'h0);
    chk("addr_err_access", 32'(addr_err), 32'(t == 4));
    chk("ram_we_access", 32'(ram_we), 32'(we && t == 0));
    if (t == 0) chk("ram_addr_access", 32'(ram_addr), 32'(a[11:2]));
    chk("int_access", 32'(counter_int), 32'(int_at(cyc)));
    case (t)
      0:       exp = ram_rd(w);
      1:       exp = m_seg;
      2:       exp = {16'h0, sw};
      3:       exp = cnt_at(cyc);
      default: exp = 32'h0;
    endcase
    if (!we) m_din = exp;
    else begin
      case (t)
        0: m_ram[w] = d;
        1: m_seg = d;
        2: m_led = d[7:0];
        3: begin m_load = d; m_lc = cyc + 1; end
        default: ;
      endcase
    end
    @(negedge clk);
    chk("rdy_done", 32'(MIO_ready), 32'h1);
    chk("data_in", Data_in, m_din);
    chk("ram_we_done", 32'(ram_we), 32'h0);
    chk("addr_err_done", 32'(addr_err), 32'h0);
    chk("seg", seg, m_seg);
    chk("led", 32'(led), 32'(m_led));
    chk("int_done", 32'(counter_int), 32'(int_at(cyc)));
    if (chained) chk("ready_spacing", 32'(cyc - last_rdy), 32'd3);
    last_rdy = cyc;
    chained = hold;
    if (!hold) begin
      CPU_MIO = 1'b0;
      @(negedge clk);
      chk("rdy_after", 32'(MIO_ready), 32'h0);
      chk("int_after", 32'(counter_int), 32'(int_at(cyc)));
    end
  endtask

  task automatic model_reset();
    m_seg = 0; m_led = 0; m_din = 0; m_load = 0; m_lc = cyc;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_rdy"},  32'(MIO_ready), 32'h0);
    chk({tag, "_din"},  Data_in, 32'h0);
    chk({tag, "_we"},   32'(ram_we), 32'h0);
    chk({tag, "_led"},  32'(led), 32'h0);
    chk({tag, "_seg"},  seg, 32'h0);
    chk({tag, "_int"},  32'(counter_int), 32'h0);
    chk({tag, "_aerr"}, 32'(addr_err), 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a, d;
    bit we, hold;
    reset = 1'b1; CPU_MIO = 1'b0; mem_w = 1'b0; Addr_out = 0; Data_out = 0; sw = 0;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    model_reset();
    chk_reset_state("reset");

    // RAM write/read
    tx(1, 32'h0000_0010, 32'hDEAD_BEEF, 0);
    tx(0, 32'h0000_0010, 32'h0, 0);

    // SEG / LED / switch port
    tx(1, 32'hE000_0000, 32'h1234_5678, 0);
    tx(1, 32'hF000_0000, 32'h0000_01A5, 0);
    sw = 16'hBEEF;
    tx(0, 32'hF000_0000, 32'h0, 0);
    tx(0, 32'hE000_0000, 32'h0, 0);

    // counter: run to zero, sticky int, clear by reload, reload on the 1->0 edge
    tx(1, 32'hF000_0004, 32'd3, 0);
    tick_chk(6);
    tx(0, 32'hF000_0004, 32'h0, 0);
    tx(1, 32'hF000_0004, 32'd5, 0);
    tx(0, 32'hF000_0004, 32'h0, 0);
    tick_chk(8);
    tx(1, 32'hF000_0004, 32'd3, 0);
    tx(1, 32'hF000_0004, 32'd7, 0);
    tick_chk(3);
    tx(0, 32'hF000_0004, 32'h0, 0);
    tx(1, 32'hF000_0004, 32'd0, 0);
    tick_chk(2);

    // unmapped
    tx(0, 32'h8000_0000, 32'h0, 0);
    tx(1, 32'h8000_0000, 32'h5555_AAAA, 0);
    tx(0, 32'h0000_0010, 32'h0, 0);

    // reset during ACCESS of a RAM write
    tx(1, 32'hF000_0004, 32'd2, 0);
    CPU_MIO = 1'b1; mem_w = 1'b1; Addr_out = 32'h0000_0020; Data_out = 32'hCAFE_F00D;
    @(negedge clk);
    chk("ram_we_before_reset", 32'(ram_we), 32'h1);
    reset = 1'b1;
    #1;
    chk("ram_we_in_reset", 32'(ram_we), 32'h0);
    CPU_MIO = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    chk_reset_state("midreset");
    tick_chk(2);
    tx(0, 32'h0000_0020, 32'h0, 0);

    // back-to-back reads with CPU_MIO held
    tx(1, 32'h0000_0004, 32'h1111_2222, 0);
    tx(1, 32'h0000_0008, 32'h3333_4444, 0);
    tx(0, 32'h0000_0004, 32'h0, 1);
    tx(0, 32'h0000_0008, 32'h0, 0);

    // randomized traffic
    for (int i = 0; i < 120; i++) begin
      case ($urandom_range(0, 6))
        0, 1:    a = ($urandom_range(0, 7) << 2);
        2:       a = 32'h0000_0FFC;
        3:       a = 32'hE000_0000;
        4:       a = 32'hF000_0000;
        5:       a = 32'hF000_0004;
        default: case ($urandom_range(0, 3))
                   0: a = 32'h0000_1000;
                   1: a = 32'hF000_0008;
                   2: a = 32'h8000_0000 | ($urandom & 32'h0FFF_FFFC);
                   default: a = 32'hE000_0004;
                 endcase
      endcase
      a  = a | 32'($urandom_range(0, 3));
      we = 1'($urandom_range(0, 1));
      d  = (tgt_of(a) == 3) ? 32'($urandom_range(0, 8)) : $urandom;
      if (!chained) begin
        sw = 16'($urandom);
        tick_chk($urandom_range(0, 3));
      end
      hold = (i != 119) && ($urandom_range(0, 3) == 0);
      tx(we, a, d, hold);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
